// File: rtl/loader_pkg.sv
// Shared encodings and constants for the UART program loader.
// Used by the receiver core and by the loader top level.
package loader_pkg;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    typedef enum logic [2:0] {
        L_LEN_HI,
        L_LEN_LO,
        L_DATA,
        L_WRITE,
        L_DONE,
        L_ERROR
    } ld_state_t;

    localparam int CLKS_PER_BIT   = 868;
    localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling, LSB first.
// Emits a one-cycle byte_valid on a good stop bit, or stop_err on a bad one.
import loader_pkg::*;

module uart_rx_core #(
    parameter int clks_per_bit = CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       stop_err
);

    localparam int CNT_W = $clog2(clks_per_bit);
    localparam logic [CNT_W-1:0] HALF = CNT_W'(clks_per_bit / 2);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(clks_per_bit - 1);

    rx_state_t        state, state_next;
    logic             rx_meta, rx_sync;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;
    logic             sample_bit;

    // NOTE: every sequential assignment is non-blocking so that all flops
    // update together and simulation order cannot change behaviour.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            state   <= RX_IDLE;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            state   <= state_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave a signal unassigned and infer a latch.
    always_comb begin
        state_next = state;
        sample_bit = 1'b0;
        byte_valid = 1'b0;
        stop_err   = 1'b0;
        case (state)
            RX_IDLE:  if (!rx_sync) state_next = RX_START;
            RX_START: if (cnt == HALF) state_next = rx_sync ? RX_IDLE : RX_DATA;
            RX_DATA: begin
                if (cnt == LAST) begin
                    sample_bit = 1'b1;
                    if (bit_idx == 3'd7) state_next = RX_STOP;
                end
            end
            RX_STOP: begin
                if (cnt == LAST) begin
                    state_next = RX_IDLE;
                    byte_valid = rx_sync;
                    stop_err   = !rx_sync;
                end
            end
            default: state_next = RX_IDLE;
        endcase
    end

    // The counter restarts on every state change and after each data sample,
    // so once aligned to mid start bit it stays on mid-bit for the frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            if (state_next != state || state == RX_IDLE || sample_bit)
                cnt <= '0;
            else
                cnt <= cnt + 1'b1;

            if (state == RX_START)
                bit_idx <= '0;
            else if (sample_bit)
                bit_idx <= bit_idx + 3'd1;

            if (sample_bit)
                shreg <= {rx_sync, shreg[7:1]};
        end
    end

    assign rx_byte = shreg;

endmodule

// File: rtl/uart_program_loader.sv
// Streams a length-prefixed, big-endian program image from UART into
// instruction memory, holding the CPU until the last word is written.
import loader_pkg::*;

module uart_program_loader #(
    parameter int clks_per_bit = CLKS_PER_BIT,
    parameter int instr_size   = 32,
    parameter int addr_width   = 32,
    parameter int max_words    = 8144
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx,
    output logic                  mem_we,
    output logic [addr_width-1:0] mem_addr,
    output logic [instr_size-1:0] mem_data,
    output logic                  hold_cpu,
    output logic                  load_done,
    output logic                  frame_err,
    output logic [15:0]           words_loaded
);

    localparam int BC_W = $clog2(BYTES_PER_WORD);
    localparam logic [BC_W-1:0] LAST_BYTE = BC_W'(BYTES_PER_WORD - 1);
    localparam logic [15:0]     MAX_N     = 16'(max_words);

    ld_state_t             state, state_next;
    logic [7:0]            rx_byte;
    logic                  byte_valid, stop_err;
    logic [15:0]           len, len_n, words_next;
    logic [instr_size-1:0] asm_word, asm_next;
    logic [BC_W-1:0]       byte_cnt;

    uart_rx_core #(.clks_per_bit(clks_per_bit)) u_rx (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .rx_byte   (rx_byte),
        .byte_valid(byte_valid),
        .stop_err  (stop_err)
    );

    assign len_n      = {len[15:8], rx_byte};
    assign words_next = words_loaded + 16'd1;
    assign asm_next   = {asm_word[instr_size-9:0], rx_byte};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= L_LEN_HI;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            L_LEN_HI: begin
                if (stop_err)        state_next = L_ERROR;
                else if (byte_valid) state_next = L_LEN_LO;
            end
            L_LEN_LO: begin
                if (stop_err) state_next = L_ERROR;
                else if (byte_valid) begin
                    if (len_n == 16'd0)     state_next = L_DONE;
                    else if (len_n > MAX_N) state_next = L_ERROR;
                    else                    state_next = L_DATA;
                end
            end
            L_DATA: begin
                if (stop_err) state_next = L_ERROR;
                else if (byte_valid && byte_cnt == LAST_BYTE) state_next = L_WRITE;
            end
            L_WRITE:  state_next = (words_next == len) ? L_DONE : L_DATA;
            L_DONE:   state_next = L_DONE;
            L_ERROR:  state_next = L_ERROR;
            default:  state_next = L_ERROR;
        endcase
    end

    // mem_addr/mem_data are captured with the last byte so they are stable
    // through the write cycle and hold afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len          <= '0;
            asm_word     <= '0;
            byte_cnt     <= '0;
            words_loaded <= '0;
            mem_addr     <= '0;
            mem_data     <= '0;
            frame_err    <= 1'b0;
            load_done    <= 1'b0;
        end else begin
            load_done <= (state_next == L_DONE) && (state != L_DONE);
            if (state_next == L_ERROR) frame_err <= 1'b1;

            if (byte_valid) begin
                case (state)
                    L_LEN_HI: len[15:8] <= rx_byte;
                    L_LEN_LO: len[7:0]  <= rx_byte;
                    L_DATA: begin
                        asm_word <= asm_next;
                        byte_cnt <= byte_cnt + 1'b1;
                        if (byte_cnt == LAST_BYTE) begin
                            mem_data <= asm_next;
                            mem_addr <= addr_width'({words_loaded, 2'b00});
                        end
                    end
                    default: ;
                endcase
            end

            if (state == L_WRITE && words_loaded != len)
                words_loaded <= words_next;
        end
    end

    assign mem_we   = (state == L_WRITE);
    assign hold_cpu = (state != L_DONE);

endmodule

// File: tb/tb_uart_program_loader.sv
// Directed bench for uart_program_loader: writes are checked against a
// scoreboard queue filled before each image is sent.
module tb_uart_program_loader;
    import loader_pkg::*;

    localparam int CPB = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic        hold_cpu;
    logic        load_done;
    logic        frame_err;
    logic [15:0] words_loaded;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t sb[$];
    int  n_checks = 0;
    int  n_fail   = 0;
    int  cyc      = 0;
    int  we_cnt   = 0;
    int  done_cnt = 0;
    int  bv_cnt   = 0;
    int  last_we_cyc = 0;
    int  done_cyc    = 0;
    int  w0, d0, b0;

    uart_program_loader #(.clks_per_bit(CPB)) dut (
        .clk         (clk),
        .rst         (rst),
        .rx          (rx),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data),
        .hold_cpu    (hold_cpu),
        .load_done   (load_done),
        .frame_err   (frame_err),
        .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin : monitor
        wr_t e;
        if (dut.u_rx.byte_valid === 1'b1) bv_cnt++;
        if (load_done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (mem_we === 1'b1) begin
            we_cnt++;
            last_we_cyc = cyc;
            check("write_expected", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("wr_addr", 64'(mem_addr), 64'(e.addr));
                check("wr_data", 64'(mem_data), 64'(e.data));
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_bit = 1'b1);
        rx = 1'b0;
        repeat (CPB) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(posedge clk);
        end
        rx = stop_bit;
        repeat (CPB) @(posedge clk);
        rx = 1'b1;
    endtask

    task automatic idle_bits(input int n);
        rx = 1'b1;
        repeat (n * CPB) @(posedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;
        idle_bits(1);
    endtask

    task automatic wait_release(input int max_cycles);
        int n = 0;
        while (hold_cpu !== 1'b0 && n < max_cycles) begin
            @(posedge clk);
            n++;
        end
        #1 check("release_in_time", 64'(hold_cpu), 64'd0);
    endtask

    initial begin : watchdog
        #3ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        rx  = 1'b1;

        // Reset asserted between edges must act immediately
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_mem_we",    64'(mem_we),       64'd0);
        check("rst_mem_addr",  64'(mem_addr),     64'd0);
        check("rst_mem_data",  64'(mem_data),     64'd0);
        check("rst_hold_cpu",  64'(hold_cpu),     64'd1);
        check("rst_load_done", 64'(load_done),    64'd0);
        check("rst_frame_err", 64'(frame_err),    64'd0);
        check("rst_words",     64'(words_loaded), 64'd0);
        @(posedge clk);
        #2 rst = 1'b0;
        idle_bits(1);

        // Basic two-word load
        sb.push_back('{32'h0, 32'hDEADBEEF});
        sb.push_back('{32'h4, 32'h12345678});
        w0 = we_cnt; d0 = done_cnt;
        send_byte(8'h00); send_byte(8'h02);
        send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
        send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
        wait_release(4 * CPB);
        repeat (3) @(posedge clk);
        #1;
        check("basic_writes",    64'(we_cnt - w0),             64'd2);
        check("basic_done",      64'(done_cnt - d0),           64'd1);
        check("basic_done_lat",  64'(done_cyc - last_we_cyc),  64'd1);
        check("basic_words",     64'(words_loaded),            64'd2);
        check("basic_frame_err", 64'(frame_err),               64'd0);
        check("basic_sb_empty",  64'(sb.size()),               64'd0);
        check("basic_addr_hold", 64'(mem_addr),                64'h4);
        check("basic_data_hold", 64'(mem_data),                64'h12345678);

        // Asynchronous reset out of L_DONE
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst2_hold_cpu", 64'(hold_cpu),     64'd1);
        check("rst2_words",    64'(words_loaded), 64'd0);
        check("rst2_mem_data", 64'(mem_data),     64'd0);
        @(posedge clk);
        #2 rst = 1'b0;
        idle_bits(1);

        // Empty image
        w0 = we_cnt; d0 = done_cnt;
        send_byte(8'h00); send_byte(8'h00);
        wait_release(2 * CPB);
        repeat (2) @(posedge clk);
        #1;
        check("empty_writes",    64'(we_cnt - w0),   64'd0);
        check("empty_done",      64'(done_cnt - d0), 64'd1);
        check("empty_words",     64'(words_loaded),  64'd0);
        check("empty_frame_err", 64'(frame_err),     64'd0);

        // Framing error during data
        do_reset();
        w0 = we_cnt; d0 = done_cnt;
        send_byte(8'h00); send_byte(8'h01); send_byte(8'hAA);
        send_byte(8'h55, 1'b0);
        idle_bits(3);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        idle_bits(2);
        #1;
        check("ferr_frame_err", 64'(frame_err),      64'd1);
        check("ferr_hold_cpu",  64'(hold_cpu),       64'd1);
        check("ferr_writes",    64'(we_cnt - w0),    64'd0);
        check("ferr_done",      64'(done_cnt - d0),  64'd0);
        check("ferr_words",     64'(words_loaded),   64'd0);
        check("ferr_state",     64'(dut.state),      64'(L_ERROR));

        // Oversize length (max_words + 1)
        do_reset();
        w0 = we_cnt;
        send_byte(8'h1F); send_byte(8'hD1);
        repeat (4) @(posedge clk);
        #1;
        check("over_frame_err", 64'(frame_err),   64'd1);
        check("over_state",     64'(dut.state),   64'(L_ERROR));
        check("over_hold_cpu",  64'(hold_cpu),    64'd1);
        check("over_writes",    64'(we_cnt - w0), 64'd0);

        // Exactly max_words is accepted
        do_reset();
        send_byte(8'h1F); send_byte(8'hD0);
        repeat (4) @(posedge clk);
        #1;
        check("max_frame_err", 64'(frame_err), 64'd0);
        check("max_state",     64'(dut.state), 64'(L_DATA));

        // Short low glitch must not produce a byte
        do_reset();
        b0 = bv_cnt;
        @(posedge clk);
        rx = 1'b0;
        repeat (4) @(posedge clk);
        rx = 1'b1;
        idle_bits(3);
        #1;
        check("glitch_no_byte", 64'(bv_cnt - b0), 64'd0);
        check("glitch_state",   64'(dut.state),   64'(L_LEN_HI));

        // Reset mid-load, then a fresh one-word load
        w0 = we_cnt;
        send_byte(8'h00); send_byte(8'h01);
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_hold_cpu", 64'(hold_cpu),    64'd1);
        check("abort_writes",   64'(we_cnt - w0), 64'd0);
        @(posedge clk);
        #2 rst = 1'b0;
        idle_bits(1);
        sb.push_back('{32'h0, 32'h01020304});
        w0 = we_cnt; d0 = done_cnt;
        send_byte(8'h00); send_byte(8'h01);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        wait_release(4 * CPB);
        repeat (2) @(posedge clk);
        #1;
        check("reload_writes",   64'(we_cnt - w0),   64'd1);
        check("reload_done",     64'(done_cnt - d0), 64'd1);
        check("reload_words",    64'(words_loaded),  64'd1);
        check("reload_sb_empty", 64'(sb.size()),     64'd0);
        check("reload_frame",    64'(frame_err),     64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
